logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width; legal values are 8 to 64.
REQ-002 Clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 Rst  in  1  reset, asynchronous, active-high.
REQ-004 In_Valid  in  1 / In_Ready  out  1  form the input handshake; an op is accepted when both are 1 on a Clk edge.
REQ-005 Op  in  3  operation: 000 AND, 001 ORR, 010 EOR, 011 BIC, 100 MVN, 101 TST, 110 TEQ, 111 MOV.
REQ-006 Cond  in  4  condition code: 0 EQ, 1 NE, 2 CS, 3 CC, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, 10 GE, 11 LT, 12 GT, 13 LE, 14 AL, 15 NV.
REQ-007 S  in  1  set-flags request.
REQ-008 In1, In2  in  WIDTH  operands.
REQ-009 Flag_Load  in  1 / Flag_In  in  4  perform a direct write of the flag register.
REQ-010 Out_Valid  out  1 / Out_Ready  in  1  form the output handshake.
REQ-011 Result  out  WIDTH  registered result.
REQ-012 Executed  out  1  registered; 1 if the condition passed.
REQ-013 Flag  out  4  current flag register, bit order [3]=N, [2]=Z, [1]=C, [0]=V.

Function
REQ-014 In_Ready SHALL equal (!Out_Valid || Out_Ready), which gives single-stage buffering, one op per cycle at full throughput, and latency of 1 cycle from accept to Out_Valid.
REQ-015 Cond SHALL be evaluated against the flag register value before the accepting edge, using ARM semantics: HI = C&!Z, GE = N==V, GT = !Z&(N==V), AL = always true, NV = never.
REQ-016 On a condition pass, the logic value SHALL be: AND In1&In2, ORR In1|In2, EOR In1^In2, BIC In1&~In2, MVN ~In2, MOV In2, TST In1&In2, TEQ In1^In2.
REQ-017 For executed AND/ORR/EOR/BIC/MVN/MOV, Result SHALL be the logic value.
REQ-018 For TST/TEQ, Result SHALL be In1 and the flags SHALL update regardless of S.
REQ-019 Flag update SHALL set N = msb of the logic value and Z = (logic value == 0); C and V are preserved.
REQ-020 Flags SHALL update only when the op is executed and either S=1 or Op is TST/TEQ.
REQ-021 On a condition fail, the output SHALL be Result = In1 and Executed = 0, with the flag register unchanged.
REQ-022 The flag update SHALL occur on the accepting edge, so the next accepted op's Cond sees the new flags with no bubble.
REQ-023 When Flag_Load and a flag-updating accept occur on the same edge, Flag_In SHALL win.
REQ-024 Flag_Load SHALL be honoured independent of the handshakes.
REQ-025 While Out_Valid=1 and Out_Ready=0, Result, Executed and Out_Valid SHALL hold stable, and no input SHALL be accepted.
REQ-026 Out_Valid SHALL drop after an output handshake only if no new accept occurs on the same edge.
REQ-027 All arithmetic SHALL be bitwise at WIDTH, with no carry out of the result.

Reset
REQ-028 Rst=1 SHALL asynchronously clear Out_Valid, Executed, Result (all zeros) and Flag (0000).
REQ-029 In_Ready SHALL read 1 after reset.
REQ-030 Reset mid-transaction SHALL discard the buffered result, which is never presented.
REQ-031 The first accept SHALL take place on the first Clk edge after Rst falls.

Structure
REQ-032 Package logic_unit_pkg SHALL hold the Op encodings, the Cond encodings and the flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
REQ-033 One combinational sub-module, cond_check, SHALL map (Cond, Flag) to a pass bit.
REQ-034 The remaining logic SHALL live in logic_unit_pipe.

Verification
REQ-035 Flags 0000, In1=2, In2=3, AND, AL, S=1 -> Result=2, Executed=1, Flag=0000 one cycle after accept.
REQ-036 In1=0xFFFFFFFA, In2=0xFFFFFFFE, AND, AL, S=1 -> Result=0xFFFFFFFA, Flag=1000.
REQ-037 Repeating REQ-036 with S=0 from flags 0011 -> Flag stays 0011.
REQ-038 TST In1=10, In2=5 -> Result=10, Flag Z=1; the next-cycle op MOV In2=7, Cond=NE -> Executed=0, Result=In1, flags unchanged.
REQ-039 Backpressure: hold Out_Ready=0 for 3 cycles with In_Valid=1 -> In_Ready=0, Result stable; release -> one output accepted and the next op issued on the same edge.
REQ-040 Assert Rst while Out_Valid=1 -> Out_Valid, Result and Flag clear immediately.
REQ-041 Flag_Load=1 with Flag_In=0101 together with ANDS producing Z=1 -> Flag=0101.
REQ-042 A WIDTH=8 instance with In1=0xFF, In2=0x09, BIC -> Result=0xF6.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared encodings for the logic unit: operand/flag widths, op and condition
// codes, and the flag register bit positions.
package logic_unit_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned COND_W = 4;
  localparam int unsigned FLAG_W = 4;

  // Flag register bit positions: [3]=N, [2]=Z, [1]=C, [0]=V
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 3'b000,
    OP_ORR = 3'b001,
    OP_EOR = 3'b010,
    OP_BIC = 3'b011,
    OP_MVN = 3'b100,
    OP_TST = 3'b101,
    OP_TEQ = 3'b110,
    OP_MOV = 3'b111
  } op_e;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_MI = 4'd4,
    COND_PL = 4'd5,
    COND_VS = 4'd6,
    COND_VC = 4'd7,
    COND_HI = 4'd8,
    COND_LS = 4'd9,
    COND_GE = 4'd10,
    COND_LT = 4'd11,
    COND_GT = 4'd12,
    COND_LE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM-style condition evaluator.
// Ports: cond   - condition code
//        flag   - flag register {N,Z,C,V}
//        pass_c - 1 when the condition holds for the given flags
module cond_check
  import logic_unit_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLAG_W-1:0] flag,
  output logic              pass_c
);

  logic n, z, c, v;

  assign n = flag[FLAG_N];
  assign z = flag[FLAG_Z];
  assign c = flag[FLAG_C];
  assign v = flag[FLAG_V];

  // Condition decode
  always_comb begin
    pass_c = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass_c = z;
      COND_NE: pass_c = !z;
      COND_CS: pass_c = c;
      COND_CC: pass_c = !c;
      COND_MI: pass_c = n;
      COND_PL: pass_c = !n;
      COND_VS: pass_c = v;
      COND_VC: pass_c = !v;
      COND_HI: pass_c = c && !z;
      COND_LS: pass_c = !c || z;
      COND_GE: pass_c = (n == v);
      COND_LT: pass_c = (n != v);
      COND_GT: pass_c = !z && (n == v);
      COND_LE: pass_c = z || (n != v);
      COND_AL: pass_c = 1'b1;
      COND_NV: pass_c = 1'b0;
      default: pass_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Single-stage pipelined conditional logic unit with an N/Z/C/V flag register.
// Ports: Clk, Rst (async, active-high)
//        In_Valid/In_Ready   - input handshake (Op, Cond, S, In1, In2)
//        Flag_Load/Flag_In   - direct flag register write, independent of handshakes
//        Out_Valid/Out_Ready - output handshake (Result, Executed)
//        Flag                - current flag register {N,Z,C,V}
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [OP_W-1:0]   Op,
  input  logic [COND_W-1:0] Cond,
  input  logic              S,
  input  logic [WIDTH-1:0]  In1,
  input  logic [WIDTH-1:0]  In2,
  input  logic              Flag_Load,
  input  logic [FLAG_W-1:0] Flag_In,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [WIDTH-1:0]  Result,
  output logic              Executed,
  output logic [FLAG_W-1:0] Flag
);

  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH must be in 8..64");
  end

  logic             accept;
  logic             cond_pass;
  logic             is_test;
  logic             flag_upd;
  logic [WIDTH-1:0] logic_val;
  logic [WIDTH-1:0] res_next;
  logic [FLAG_W-1:0] flag_next;

  // Output buffer can take a new op when empty or being drained this edge
  assign In_Ready = !Out_Valid || Out_Ready;
  assign accept   = In_Valid && In_Ready;

  cond_check u_cond_check (
    .cond   (Cond),
    .flag   (Flag),
    .pass_c (cond_pass)
  );

  // Logic value, result selection and flag update
  always_comb begin
    logic_val = '0;
    case (op_e'(Op))
      OP_AND:  logic_val = In1 & In2;
      OP_ORR:  logic_val = In1 | In2;
      OP_EOR:  logic_val = In1 ^ In2;
      OP_BIC:  logic_val = In1 & ~In2;
      OP_MVN:  logic_val = ~In2;
      OP_TST:  logic_val = In1 & In2;
      OP_TEQ:  logic_val = In1 ^ In2;
      OP_MOV:  logic_val = In2;
      default: logic_val = '0;
    endcase

    is_test  = (op_e'(Op) == OP_TST) || (op_e'(Op) == OP_TEQ);
    // Test ops and failed conditions pass In1 through unchanged
    res_next = (cond_pass && !is_test) ? logic_val : In1;
    flag_upd = accept && cond_pass && (S || is_test);

    flag_next         = Flag;
    flag_next[FLAG_N] = logic_val[WIDTH-1];
    flag_next[FLAG_Z] = (logic_val == '0);
  end

  // Output stage
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Out_Valid <= 1'b0;
      Result    <= '0;
      Executed  <= 1'b0;
    end else if (accept) begin
      Out_Valid <= 1'b1;
      Result    <= res_next;
      Executed  <= cond_pass;
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

  // Flag register; a direct load overrides an op-driven update
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Flag <= '0;
    end else if (Flag_Load) begin
      Flag <= Flag_In;
    end else if (flag_upd) begin
      Flag <= flag_next;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=32 plus a WIDTH=8 instance).
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        In_Valid, S, Flag_Load, Out_Ready;
  logic [2:0]  Op;
  logic [3:0]  Cond, Flag_In;
  logic [31:0] In1, In2;
  logic        In_Ready, Out_Valid, Executed;
  logic [31:0] Result;
  logic [3:0]  Flag;

  logic        In_Valid8, S8, Flag_Load8, Out_Ready8;
  logic [2:0]  Op8;
  logic [3:0]  Cond8, Flag_In8;
  logic [7:0]  In1_8, In2_8;
  logic        In_Ready8, Out_Valid8, Executed8;
  logic [7:0]  Result8;
  logic [3:0]  Flag8;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  logic_unit_pipe #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Op(Op), .Cond(Cond), .S(S), .In1(In1), .In2(In2),
    .Flag_Load(Flag_Load), .Flag_In(Flag_In), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Result(Result), .Executed(Executed), .Flag(Flag)
  );

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid8), .In_Ready(In_Ready8),
    .Op(Op8), .Cond(Cond8), .S(S8), .In1(In1_8), .In2(In2_8),
    .Flag_Load(Flag_Load8), .Flag_In(Flag_In8), .Out_Valid(Out_Valid8),
    .Out_Ready(Out_Ready8), .Result(Result8), .Executed(Executed8), .Flag(Flag8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op, let it be accepted on the next edge, sample 1 time unit later
  task automatic send(input op_e op, input cond_e cond, input logic s,
                      input logic [31:0] a, input logic [31:0] b);
    In_Valid = 1'b1; Op = op; Cond = cond; S = s; In1 = a; In2 = b;
    @(posedge Clk); #1;
    In_Valid = 1'b0; Flag_Load = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; In_Valid = 0; S = 0; Flag_Load = 0; Out_Ready = 1;
    Op = 3'b000; Cond = 4'd14; Flag_In = 4'h0; In1 = '0; In2 = '0;
    In_Valid8 = 0; S8 = 0; Flag_Load8 = 0; Out_Ready8 = 1;
    Op8 = 3'b000; Cond8 = 4'd14; Flag_In8 = 4'h0; In1_8 = '0; In2_8 = '0;
    #12;
    check("rst_out_valid", 64'(Out_Valid), 64'd0);
    check("rst_result",    64'(Result),    64'd0);
    check("rst_executed",  64'(Executed),  64'd0);
    check("rst_flag",      64'(Flag),      64'h0);
    check("rst_in_ready",  64'(In_Ready),  64'd1);
    @(negedge Clk); Rst = 1'b0;

    // AND 2&3 = 2, nonzero positive -> flags stay 0000
    send(OP_AND, COND_AL, 1'b1, 32'd2, 32'd3);
    check("and_valid",  64'(Out_Valid), 64'd1);
    check("and_result", 64'(Result),    64'd2);
    check("and_exec",   64'(Executed),  64'd1);
    check("and_flag",   64'(Flag),      64'h0);

    // Negative result sets N
    send(OP_AND, COND_AL, 1'b1, 32'hFFFF_FFFA, 32'hFFFF_FFFE);
    check("ands_neg_result", 64'(Result), 64'hFFFF_FFFA);
    check("ands_neg_flag",   64'(Flag),   64'h8);

    // Direct load to 0011, then same AND with S=0 leaves flags alone
    Flag_Load = 1'b1; Flag_In = 4'b0011;
    @(posedge Clk); #1; Flag_Load = 1'b0;
    check("flag_load", 64'(Flag), 64'h3);
    send(OP_AND, COND_AL, 1'b0, 32'hFFFF_FFFA, 32'hFFFF_FFFE);
    check("and_nos_result", 64'(Result), 64'hFFFF_FFFA);
    check("and_nos_flag",   64'(Flag),   64'h3);

    // TST 10&5 = 0 -> Z=1, C/V kept; Result = In1
    send(OP_TST, COND_AL, 1'b0, 32'd10, 32'd5);
    check("tst_result", 64'(Result), 64'd10);
    check("tst_flag",   64'(Flag),   64'h7);
    // Back-to-back MOV NE sees Z=1 and fails
    send(OP_MOV, COND_NE, 1'b1, 32'h1234, 32'd7);
    check("mov_ne_result", 64'(Result),   64'h1234);
    check("mov_ne_exec",   64'(Executed), 64'd0);
    check("mov_ne_flag",   64'(Flag),     64'h7);

    // TEQ EQ passes (Z=1); 0x80000000^0 -> N=1,Z=0
    send(OP_TEQ, COND_EQ, 1'b0, 32'h8000_0000, 32'h0);
    check("teq_result", 64'(Result), 64'h8000_0000);
    check("teq_flag",   64'(Flag),   64'hB);

    // Flags 1011: GT passes (Z=0, N==V), LT fails
    send(OP_EOR, COND_GT, 1'b0, 32'hF0, 32'hFF);
    check("eor_gt_result", 64'(Result),   64'h0F);
    check("eor_gt_exec",   64'(Executed), 64'd1);
    send(OP_ORR, COND_LT, 1'b1, 32'hAA, 32'h55);
    check("orr_lt_result", 64'(Result),   64'hAA);
    check("orr_lt_exec",   64'(Executed), 64'd0);
    check("orr_lt_flag",   64'(Flag),     64'hB);

    // HI passes (C=1,Z=0): BIC with S -> N=0,Z=0
    send(OP_BIC, COND_HI, 1'b1, 32'hFF, 32'h0F);
    check("bic_hi_result", 64'(Result), 64'hF0);
    check("bic_hi_flag",   64'(Flag),   64'h3);
    // MVN of all ones -> 0, Z=1
    send(OP_MVN, COND_AL, 1'b1, 32'h1, 32'hFFFF_FFFF);
    check("mvn_result", 64'(Result), 64'h0);
    check("mvn_flag",   64'(Flag),   64'h7);
    // NV never executes
    send(OP_MOV, COND_NV, 1'b1, 32'd9, 32'd3);
    check("mov_nv_result", 64'(Result),   64'd9);
    check("mov_nv_exec",   64'(Executed), 64'd0);
    // CS passes (C=1)
    send(OP_MOV, COND_CS, 1'b0, 32'd9, 32'h77);
    check("mov_cs_result", 64'(Result), 64'h77);

    // Direct load collides with ANDS producing Z=1 -> load wins
    Flag_Load = 1'b1; Flag_In = 4'b0101;
    send(OP_AND, COND_AL, 1'b1, 32'h1, 32'h2);
    check("load_win_flag",   64'(Flag),   64'h5);
    check("load_win_result", 64'(Result), 64'h0);

    // Backpressure: output held, new op stalled
    Out_Ready = 1'b0;
    In_Valid = 1'b1; Op = OP_ORR; Cond = COND_AL; S = 1'b0; In1 = 32'h100; In2 = 32'h001;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      check("bp_in_ready", 64'(In_Ready),  64'd0);
      check("bp_valid",    64'(Out_Valid), 64'd1);
      check("bp_result",   64'(Result),    64'h0);
    end
    Out_Ready = 1'b1;
    @(posedge Clk); #1; In_Valid = 1'b0;
    check("bp_release_valid",  64'(Out_Valid), 64'd1);
    check("bp_release_result", 64'(Result),    64'h101);
    @(posedge Clk); #1;
    check("drain_valid",    64'(Out_Valid), 64'd0);
    check("drain_in_ready", 64'(In_Ready),  64'd1);

    // Reset while an output is pending clears immediately
    send(OP_MOV, COND_AL, 1'b1, 32'h0, 32'hABCD);
    check("pre_rst_result", 64'(Result), 64'hABCD);
    check("pre_rst_flag",   64'(Flag),   64'h1);
    Out_Ready = 1'b0;
    #3 Rst = 1'b1;
    #1;
    check("mid_rst_valid",  64'(Out_Valid), 64'd0);
    check("mid_rst_result", 64'(Result),    64'h0);
    check("mid_rst_exec",   64'(Executed),  64'd0);
    check("mid_rst_flag",   64'(Flag),      64'h0);
    @(negedge Clk); Rst = 1'b0; Out_Ready = 1'b1;
    // First edge after reset accepts
    send(OP_AND, COND_AL, 1'b1, 32'h5, 32'h3);
    check("post_rst_valid",  64'(Out_Valid), 64'd1);
    check("post_rst_result", 64'(Result),    64'h1);

    // 8-bit instance: BIC FF & ~09 = F6, msb set -> N
    In_Valid8 = 1'b1; Op8 = OP_BIC; Cond8 = COND_AL; S8 = 1'b1; In1_8 = 8'hFF; In2_8 = 8'h09;
    @(posedge Clk); #1; In_Valid8 = 1'b0;
    check("w8_bic_result", 64'(Result8),    64'hF6);
    check("w8_bic_valid",  64'(Out_Valid8), 64'd1);
    check("w8_bic_flag",   64'(Flag8),      64'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
